// File: rtl/imsharp_window_gen.sv
// Streaming 5x5 zero-padded window generator with a 4-line buffer, feeding the imsharp core.
// Defining IMSHARP_WIN_STATS_EN adds the frame_count port and its 16-bit wrapping counter.
module imsharp_window_gen #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic [7:0]   in_pixel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [199:0] win_out,
    output logic         win_valid,
    input  logic         win_ready,
    output logic         frame_done
`ifdef IMSHARP_WIN_STATS_EN
    ,
    output logic [15:0]  frame_count
`endif
);
    // state | meaning
    // FILL  | rows 0..1: buffering lines, nothing to emit yet
    // RUN   | rows 2..H-1: consume pixels and emit windows
    // FLUSH | rows H..H+1: inject zeros to emit the bottom windows
    // DONE  | hold the last window until it is accepted
    localparam int CW = $clog2(IMAGE_WIDTH + 2);
    localparam int RW = $clog2(IMAGE_HEIGHT + 2);
    localparam int AW = $clog2(IMAGE_WIDTH);

    localparam logic [CW-1:0] COL_W    = CW'(IMAGE_WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH + 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_H    = RW'(IMAGE_HEIGHT);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT + 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {FILL, RUN, FLUSH, DONE} state_t;

    state_t           state, state_nx;
    logic [RW-1:0]    ir, ir_nx;
    logic [CW-1:0]    ic, ic_nx;
    logic             consuming, emitting, out_free, advance, line_end;
    logic [7:0]       line_buf [4][IMAGE_WIDTH];
    logic [AW-1:0]    col_addr;
    logic [4:0][7:0]  column;
    logic [24:0][7:0] win_reg, win_nx;

    assign col_addr = ic[AW-1:0];

    always_comb begin
        consuming  = (state != DONE) && (ir < ROW_H) && (ic < COL_W);
        emitting   = (state != DONE) && (ir >= ROW_TWO) && (ic >= COL_TWO);
        out_free   = !win_valid || win_ready;
        advance    = (state != DONE) && (!consuming || in_valid) && (!emitting || out_free);
        in_ready   = Reset && consuming && (!emitting || out_free);
        frame_done = (state == DONE) && win_valid && win_ready;
        line_end   = advance && (ic == COL_LAST);
    end

    // Row ir-4+h lives in slot (ir+h) mod 4; rows above the frame or below its bottom read as zero.
    always_comb begin
        column = '0;
        for (int h = 0; h < 4; h++) begin
            if ((ic < COL_W) && (int'(ir) + h >= 4) && (int'(ir) + h < IMAGE_HEIGHT + 4))
                column[h] = line_buf[ir[1:0] + 2'(h)][col_addr];
        end
        if (consuming)
            column[4] = in_pixel;
    end

    always_comb begin
        win_nx = '0;
        for (int h = 0; h < 5; h++) begin
            for (int w = 0; w < 4; w++) begin
                if (ic != '0)
                    win_nx[h*5+w] = win_reg[h*5+w+1];
            end
            win_nx[h*5+4] = column[h];
        end
    end

    always_comb begin
        state_nx = state;
        ir_nx    = ir;
        ic_nx    = ic;
        if (advance) begin
            if (ic == COL_LAST) begin
                ic_nx = '0;
                ir_nx = ir + 1'b1;
            end else begin
                ic_nx = ic + 1'b1;
            end
        end
        case (state)
            FILL:    if (line_end && ir == ROW_ONE) state_nx = RUN;
            RUN:     if (line_end && ir == ROW_H - 1'b1) state_nx = FLUSH;
            FLUSH: begin
                if (line_end && ir == ROW_LAST) begin
                    state_nx = DONE;
                    ir_nx    = '0;
                    ic_nx    = '0;
                end
            end
            DONE:    if (frame_done) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= FILL;
            ir        <= '0;
            ic        <= '0;
            win_reg   <= '0;
            win_out   <= '0;
            win_valid <= 1'b0;
        end else begin
            state <= state_nx;
            ir    <= ir_nx;
            ic    <= ic_nx;
            if (advance)
                win_reg <= win_nx;
            // win_out is a separate copy so it holds while non-emitting steps keep shifting win_reg.
            if (advance && emitting) begin
                win_out   <= win_nx;
                win_valid <= 1'b1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance && consuming)
            line_buf[ir[1:0]][col_addr] <= in_pixel;
    end

`ifdef IMSHARP_WIN_STATS_EN
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)
            frame_count <= '0;
        else if (frame_done)
            frame_count <= frame_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_imsharp_window_gen.sv
// Scoreboard bench for imsharp_window_gen on an 8x8 frame: full rate, stall, mid-frame reset, random gaps.
module tb_imsharp_window_gen;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int NW = W * H;

    logic         clk = 1'b0;
    logic         Reset;
    logic [7:0]   in_pixel;
    logic         in_valid;
    logic         in_ready;
    logic [199:0] win_out;
    logic         win_valid;
    logic         win_ready;
    logic         frame_done;
`ifdef IMSHARP_WIN_STATS_EN
    logic [15:0]  frame_count;
`endif

    always #5 clk = ~clk;

    imsharp_window_gen #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .win_out    (win_out),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
`ifdef IMSHARP_WIN_STATS_EN
        ,
        .frame_count(frame_count)
`endif
    );

    int           checks = 0;
    int           passes = 0;
    int           out_cnt = 0;
    int           frames_exp = 0;
    logic [7:0]   pix_q [$];
    logic [199:0] exp_q [$];
    logic [7:0]   img [NW];

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [199:0] model_win(input int r, input int c);
        logic [199:0] v;
        v = '0;
        for (int h = 0; h < 5; h++) begin
            for (int w = 0; w < 5; w++) begin
                int rr = r + h - 2;
                int cc = c + w - 2;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    v[(h*5+w)*8 +: 8] = img[rr*W + cc];
            end
        end
        return v;
    endfunction

    task automatic load_frame(input bit rnd);
        for (int i = 0; i < NW; i++) begin
            img[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
            pix_q.push_back(img[i]);
        end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back(model_win(r, c));
    endtask

    task automatic reset_checks();
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_out", win_out, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_in_ready", in_ready, 0);
`ifdef IMSHARP_WIN_STATS_EN
        chk("rst_frame_count", frame_count, 0);
`endif
    endtask

    // mode 0: full rate, 1: full rate with a 10-cycle stall on window index 4, 2: random gaps
    task automatic run(input int mode, input int max_pix, input bit timing);
        int           stall_left = 0;
        bit           stall_done = 1'b0;
        int           nin = 0;
        int           nout = 0;
        logic [199:0] held = '0;
        logic [199:0] exp_w;
        bit           acc_in, acc_out;
        for (int cyc = 0; cyc < 4000 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            in_valid  = (pix_q.size() > 0) && (mode != 2 || $urandom_range(0, 9) < 7);
            in_pixel  = (pix_q.size() > 0) ? pix_q[0] : 8'h00;
            win_ready = (mode != 2) || ($urandom_range(0, 9) < 7);
            if (mode == 1 && !stall_done && win_valid && nout == 4) begin
                stall_left = 10;
                stall_done = 1'b1;
                held       = win_out;
            end
            if (stall_left > 0)
                win_ready = 1'b0;
            #1;
            if (stall_left > 0) begin
                chk("stall_valid", win_valid, 1);
                chk("stall_in_ready", in_ready, 0);
                if (stall_left < 10)
                    chk("stall_hold", win_out, held);
                stall_left--;
            end
            if (timing && nout == 0) begin
                if (cyc < 20)
                    chk("fill_in_ready", in_ready, (cyc % 10) < 8);
                chk("first_valid", win_valid, nin >= 19);
            end
            acc_in  = in_valid && in_ready;
            acc_out = win_valid && win_ready;
            if (acc_out) begin
                exp_w = exp_q.pop_front();
                chk("window", win_out, exp_w);
                chk("frame_done", frame_done, (out_cnt % NW) == NW - 1);
                if (mode != 2 && (out_cnt % NW) == 0) begin
                    chk("w00_k0_11", win_out[95:0], 0);
                    chk("w00_k12", win_out[12*8 +: 8], 0);
                    chk("w00_k13", win_out[13*8 +: 8], 1);
                    chk("w00_k14", win_out[14*8 +: 8], 2);
                    chk("w00_k17", win_out[17*8 +: 8], 8);
                    chk("w00_k24", win_out[24*8 +: 8], 18);
                end
                if (mode != 2 && (out_cnt % NW) == NW - 1) begin
                    chk("w77_k12", win_out[12*8 +: 8], 63);
                    chk("w77_k6", win_out[6*8 +: 8], 54);
                    chk("w77_k0", win_out[0*8 +: 8], 45);
                    chk("w77_k3_4", win_out[39:24], 0);
                    chk("w77_k8_9", win_out[79:64], 0);
                    chk("w77_k13_14", win_out[119:104], 0);
                    chk("w77_k15_24", win_out[199:120], 0);
                end
                out_cnt++;
                nout++;
                if ((out_cnt % NW) == 0)
                    frames_exp++;
            end else begin
                chk("frame_done_idle", frame_done, 0);
            end
            if (acc_in) begin
                void'(pix_q.pop_front());
                nin++;
                if (max_pix > 0 && nin == max_pix)
                    break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (max_pix == 0)
            chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        Reset     = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = 8'h00;
        win_ready = 1'b1;
        #12;
        reset_checks();
        @(negedge clk);
        Reset = 1'b1;

        load_frame(1'b0);
        run(0, 0, 1'b1);

        load_frame(1'b0);
        run(1, 0, 1'b0);

        load_frame(1'b0);
        run(0, 30, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        reset_checks();
        pix_q.delete();
        exp_q.delete();
        out_cnt    = 0;
        frames_exp = 0;
        @(negedge clk);
        Reset = 1'b1;

        load_frame(1'b0);
        run(0, 0, 1'b1);

        load_frame(1'b1);
        load_frame(1'b1);
        run(2, 0, 1'b0);

`ifdef IMSHARP_WIN_STATS_EN
        chk("frame_count", frame_count, frames_exp);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
